// File: rtl/knn_topk_ctrl_if.sv
// knn_topk_ctrl_if: Avalon-MM register bus plus distance sample stream.
// master = host/datapath side, slave = knn_topk_ctrl.
interface knn_topk_ctrl_if #(
  parameter int DIST_W  = 24,
  parameter int LABEL_W = 3
);
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic               dist_valid;
  logic               dist_ready;
  logic [DIST_W-1:0]  dist_data;
  logic [LABEL_W-1:0] dist_label;
  logic               dist_last;

  modport master (
    output address, chipselect,
    output write_n, writedata,
    input  readdata,
    output dist_valid, dist_data,
    output dist_label, dist_last,
    input  dist_ready
  );

  modport slave (
    input  address, chipselect,
    input  write_n, writedata,
    output readdata,
    input  dist_valid, dist_data,
    input  dist_label, dist_last,
    output dist_ready
  );
endinterface

// File: rtl/knn_topk_ctrl.sv
// knn_topk_ctrl: keeps the K nearest (distance,label) samples sorted,
// votes on their labels and publishes the winner over Avalon-MM.
// Ports: clk, reset_n (async low), bus (knn_topk_ctrl_if.slave:
// Avalon regs + dist stream), busy; irq when KNN_TOPK_IRQ_EN defined.
// Regs: 0 CTRL, 1 K, 2 STATUS, 3 RESULT, 4 BEST.
module knn_topk_ctrl #(
  parameter int KMAX    = 16,
  parameter int DIST_W  = 24,
  parameter int LABEL_W = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  knn_topk_ctrl_if.slave bus,
  output logic           busy
`ifdef KNN_TOPK_IRQ_EN
  ,
  output logic           irq
`endif
);
  localparam int NCLASS = 2 ** LABEL_W;
  localparam int IW = (KMAX > 1) ? $clog2(KMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, COLLECT, VOTE, ARGMAX, DONE
  } state_t;

  typedef struct packed {
    logic               v;
    logic [LABEL_W-1:0] l;
    logic [DIST_W-1:0]  d;
  } slot_t;

  localparam slot_t SLOT_CLR = '{
    v: 1'b0, l: '0, d: '1
  };

  state_t             state, state_nx;
  slot_t              slot [KMAX];
  slot_t              nw;
  logic [7:0]         cnt [NCLASS];
  logic [4:0]         k_reg, kq, nval;
  logic [4:0]         wd_k, kclamp;
  logic [IW-1:0]      vi;
  logic [LABEL_W-1:0] ai, blbl, res_lbl;
  logic [7:0]         bcnt, res_cnt;
  logic [DIST_W-1:0]  best_d;
  logic               done;
  logic [KMAX-1:0]    gt, first;
  logic               wr, start, abort, go;

  wire unused_wd = &{1'b0, bus.writedata[31:5]};

  assign wr    = bus.chipselect && !bus.write_n;
  assign start = wr && bus.address == 3'd0
              && bus.writedata[0];
  assign abort = wr && bus.address == 3'd0
              && bus.writedata[1];
  assign go    = start && !abort
              && (state == IDLE || state == DONE);

  assign busy = state == COLLECT
             || state == VOTE
             || state == ARGMAX;
  assign bus.dist_ready = state == COLLECT;

  assign nw   = '{1'b1, bus.dist_label, bus.dist_data};
  assign wd_k = bus.writedata[4:0];

  always_comb begin
    unique case (1'b1)
      (wd_k == 5'd0):       kclamp = 5'd1;
      (wd_k > 5'(KMAX)):    kclamp = 5'(KMAX);
      default:              kclamp = wd_k;
    endcase
  end

  // gt is monotonic over 0..kq-1 (list sorted, invalid at tail),
  // so the first set bit is the insert point and every later set
  // bit shifts down one place. Strict > keeps equal keys stable.
  always_comb begin
    gt    = '0;
    first = '0;
    for (int i = 0; i < KMAX; i++)
      gt[i] = (5'(i) < kq)
           && (!slot[i].v || slot[i].d > bus.dist_data);
    first[0] = gt[0];
    for (int i = 1; i < KMAX; i++)
      first[i] = gt[i] && !gt[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE:
        if (start) state_nx = COLLECT;
      COLLECT:
        if (bus.dist_valid && bus.dist_last)
          state_nx = VOTE;
      VOTE:
        if (5'(vi) == kq - 5'd1) state_nx = ARGMAX;
      ARGMAX:
        if (&ai) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < KMAX; i++) slot[i] <= SLOT_CLR;
      for (int c = 0; c < NCLASS; c++) cnt[c] <= '0;
      k_reg   <= 5'd1;
      kq      <= 5'd1;
      nval    <= '0;
      vi      <= '0;
      ai      <= '0;
      blbl    <= '0;
      bcnt    <= '0;
      res_lbl <= '0;
      res_cnt <= '0;
      best_d  <= '0;
      done    <= 1'b0;
    end else begin
      if (wr && bus.address == 3'd1 && !busy)
        k_reg <= kclamp;
      if (abort) begin
        for (int i = 0; i < KMAX; i++) slot[i] <= SLOT_CLR;
        nval <= '0;
        done <= 1'b0;
      end else if (go) begin
        for (int i = 0; i < KMAX; i++) slot[i] <= SLOT_CLR;
        for (int c = 0; c < NCLASS; c++) cnt[c] <= '0;
        kq   <= k_reg;
        nval <= '0;
        vi   <= '0;
        ai   <= '0;
        blbl <= '0;
        bcnt <= '0;
        done <= 1'b0;
      end else begin
        unique case (state)
          COLLECT: if (bus.dist_valid) begin
            if (gt[0]) slot[0] <= nw;
            for (int i = 1; i < KMAX; i++)
              if (first[i])   slot[i] <= nw;
              else if (gt[i]) slot[i] <= slot[i-1];
            if (nval < kq) nval <= nval + 5'd1;
          end
          VOTE: begin
            if (slot[vi].v)
              cnt[slot[vi].l] <= cnt[slot[vi].l] + 8'd1;
            vi <= vi + IW'(1);
          end
          ARGMAX: begin
            if (cnt[ai] > bcnt) begin
              bcnt <= cnt[ai];
              blbl <= ai;
            end
            ai <= ai + LABEL_W'(1);
          end
          // the scan result lands on the last ARGMAX edge, so it
          // is published one edge after arriving here
          DONE: if (!done) begin
            done    <= 1'b1;
            res_lbl <= blbl;
            res_cnt <= bcnt;
            best_d  <= slot[0].d;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef KNN_TOPK_IRQ_EN
  logic irq_en, irq_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en  <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      if (wr && bus.address == 3'd0)
        irq_en <= bus.writedata[2];
      if (go || abort)
        irq_ack <= 1'b0;
      else if (wr && bus.address == 3'd2)
        irq_ack <= 1'b1;
    end
  end

  assign irq = done && irq_en && !irq_ack;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
`ifdef KNN_TOPK_IRQ_EN
      3'd0: bus.readdata[2] = irq_en;
`endif
      3'd1: bus.readdata[4:0] = k_reg;
      3'd2: begin
        bus.readdata[0]    = busy;
        bus.readdata[1]    = done;
        bus.readdata[12:8] = nval;
      end
      3'd3: begin
        bus.readdata[LABEL_W-1:0] = res_lbl;
        bus.readdata[15:8]        = res_cnt;
      end
      3'd4: bus.readdata[DIST_W-1:0] = best_d;
      default: ;
    endcase
  end
endmodule

// File: doc/knn_topk_ctrl.md
Name: knn_topk_ctrl

Overview:
- Avalon-MM-controlled sequencer for the KNN classification step. Consumes a stream of (distance, label) samples produced by the distance datapath and keeps the K nearest in a sorted register list.
- On end-of-stream, runs a majority vote over the kept labels and publishes the winning class to the Nios II.
- K is software-configured via this block's register map; it replaces the bare K output port as the owner of K.

Parameters:
- KMAX, 16, maximum neighbour count and sorted-list depth (2..31).
- DIST_W, 24, distance width in bits (unsigned).
- LABEL_W, 3, label width in bits; NCLASS = 2^LABEL_W vote counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux, zero wait states.
- dist_valid  in  1  sample valid.
- dist_ready  out  1  sample accept; transfer occurs when valid && ready at a clk edge.
- dist_data  in  DIST_W  sample distance.
- dist_label  in  LABEL_W  sample class label.
- dist_last  in  1  marks final sample of the query.
- busy  out  1  high in COLLECT/VOTE/ARGMAX.

Behaviour:
- Reset and clock: reset_n asynchronous active-low; clock clk.
- Reset values: state=IDLE, K reg=1, list cleared, done=0, RESULT=0, readdata reflects cleared registers, dist_ready=0, busy=0.
- Register map (a write is chipselect && !write_n):
  - 0 CTRL (W): bit0 start, bit1 abort; reads 0.
  - 1 K (R/W): [4:0]. Write is clamped on store: 0 stores 1, >KMAX stores KMAX. Write is ignored while busy. Reads return the stored value.
  - 2 STATUS (R): bit0 busy, bit1 done, [12:8] valid-entry count.
  - 3 RESULT (R): [LABEL_W-1:0] winning label, [15:8] winning vote count.
  - 4 BEST (R): [DIST_W-1:0] smallest kept distance.
  - Other addresses read 0.
- FSM states: IDLE, COLLECT, VOTE, ARGMAX, DONE.
- IDLE/DONE + start:
  - K is latched into kq.
  - All KMAX slots become invalid with distance all-ones.
  - Counters and done are cleared.
  - Next state is COLLECT.
- Start while busy is ignored.
- COLLECT:
  - dist_ready=1; one sample is accepted per cycle, with no stalls.
  - Single-cycle parallel insertion among slots 0..kq-1. The new sample goes to the first slot i whose entry is invalid or has distance strictly greater than the sample. Slots i..kq-2 shift down; slot kq-1 drops out.
  - Equal distances: the earlier sample stays ahead (stable).
  - A sample not smaller than a full list's slot kq-1 is discarded.
  - Slots >= kq are never written.
  - Accepted sample with dist_last: go to VOTE on the same edge, after inserting that sample.
- VOTE:
  - kq cycles, one slot per cycle from index 0.
  - Each valid slot increments counter[label].
  - Counters are 8 bits and never overflow, since KMAX<=31.
- ARGMAX:
  - NCLASS cycles scanning labels 0..NCLASS-1.
  - Replaces best only on a strictly greater count, so a tie resolves to the lowest label.
- DONE:
  - done=1 and RESULT/BEST are updated on entry.
  - done is visible exactly kq+NCLASS+1 edges after the edge that accepted dist_last.
  - Stays in DONE until the next start.
- Abort in any state:
  - Next edge goes to IDLE with done=0 and dist_ready=0.
  - List is invalidated; RESULT keeps its previous value.
  - Abort takes priority over start in the same write.
- Empty list at VOTE (not possible: at least one sample is always accepted).
- Fewer samples than kq: only valid slots vote; count field reports the valid number.
- dist_ready=0 outside COLLECT; samples presented then are not consumed.

Optional Feature:
- Macro: KNN_TOPK_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0) and CTRL bit2 irq_en (R/W, reset 0; CTRL reads return irq_en in bit2).
  - irq is level-high while done && irq_en.
  - Cleared by start, abort, or a write to STATUS (address 2).
- Undefined: no irq port; CTRL bit2 is ignored and reads 0.

Test Plan:
- K=3; stream (50,L1),(10,L2),(30,L2),(20,L1),(40,L3,last) -> list 10/20/30; RESULT label=2, votes=2; BEST=10; count=3; done at 3+8+1 edges after last.
- K=2; stream (5,L3),(5,L1,last) -> stable order L3 then L1; votes 1/1; tie gives label=1, votes=1.
- Write K=0 -> reads 1. Write K=20 -> reads 16. Write K=7 while busy -> K unchanged.
- K=5; two samples (8,L4),(3,L4,last) -> count=2, label=4, votes=2, BEST=3.
- Abort after 2 of 4 samples, dist_valid held high -> next edge IDLE, dist_ready=0, done=0. A restart with 1 sample (9,L6,last) -> label=6, votes=1.
- KNN_TOPK_IRQ_EN with irq_en=1 -> irq rises with done. Write to address 2 -> irq=0 next edge while done remains 1.
